count_sched: RTL
================

# count_sched

Round-robin scheduler that shares one `count_fsm` wait-timer between N requesters in the DDS calibration/ranging control path. Each requester posts a wait length; the scheduler grants one requester at a time, issues `start`/`wait_timer` to the counter, watches `flag`, and returns a per-requester done or error pulse. A watchdog aborts a service when the counter never reports expiry.

## Interface
- `N`, 4: number of requesters (2..8).
- `TW`, 16: timer width; matches the counter `wait_timer` width.
- `TIMEOUT`, 1024: watchdog limit in cycles; must exceed the largest legal wait plus counter latency.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  N  per-requester request level; held until that requester's done/err pulse.
- `req_timer`  in  N*TW  packed wait lengths; slice i = `req_timer[i*TW +: TW]`.
- `grant`  out  N  one-hot; the requester currently in service.
- `done`  out  N  one-cycle pulse; service completed normally.
- `err`  out  N  one-cycle pulse; service aborted by watchdog.
- `busy`  out  1  high from grant until the done/err cycle.
- `cur_id`  out  clog2(N)  index of granted requester; valid while `busy`.
- `tmr_start`  out  1  one-cycle start pulse to the counter.
- `tmr_wait_timer`  out  TW  wait length to the counter; stable from start until completion.
- `tmr_flag`  in  1  counter expiry pulse.
- `tmr_busy`  in  1  counter busy status.

## Operation
- States: IDLE, ISSUE, RUN.
- IDLE: if any `req` bit high, select the first set bit searching upward from round-robin pointer `ptr` (wrapping). Register `grant`, `cur_id`, latch the slice of `req_timer` into `tmr_wait_timer`, set `busy`; go to ISSUE.
- ISSUE: if latched timer == 0, bypass the counter: pulse `done[cur_id]`, release, go IDLE. Else if `tmr_busy` low, pulse `tmr_start`, clear watchdog, go RUN; if `tmr_busy` high, hold in ISSUE (no start, watchdog counting).
- RUN: watchdog increments every cycle. On `tmr_flag`: pulse `done[cur_id]`, release, go IDLE. On watchdog == TIMEOUT without flag: pulse `err[cur_id]`, release, go IDLE.
- Release: `grant` = 0, `busy` = 0 in the same cycle as the done/err pulse; `ptr` = (`cur_id`+1) mod N.
- `req_timer` is sampled only at grant; later changes ignored. A requester dropping `req` mid-service does not abort; its done/err still pulses.
- `tmr_flag` while in IDLE or ISSUE is ignored (stray). Flag and watchdog limit in the same cycle: flag wins, done pulses, no err.
- Watchdog width clog2(TIMEOUT+1); saturating, no wrap.

## Timing
- Reset values: `grant`=0, `done`=0, `err`=0, `busy`=0, `cur_id`=0, `tmr_start`=0, `tmr_wait_timer`=0, `ptr`=0, state IDLE. Reset mid-service drops everything next cycle without any done/err pulse; counter is left to finish on its own.
- All outputs registered.
- `req` high in cycle 0 (IDLE) -> `grant`, `busy`, `tmr_wait_timer` valid cycle 1 -> `tmr_start` high cycle 2 only (given `tmr_busy` low in cycle 1).
- `tmr_flag` high in cycle k -> `done` pulse and `grant`/`busy` low in cycle k+1; next grant earliest cycle k+2.
- Zero timer: grant cycle 1, `done` cycle 2, no `tmr_start`.
- Watchdog: err in cycle s+TIMEOUT+1 where s is the `tmr_start` cycle.
- Max one service in flight; no back-to-back grants without an intervening IDLE cycle.

## Test plan
- Single request: `req`=0001, timer 10, counter model flags 10 cycles after start -> one `tmr_start` with `tmr_wait_timer`=10, `done`=0001 one cycle after flag, `err` never.
- Round-robin fairness: all four `req` high continuously, timer 3 each -> grant order 0,1,2,3,0 with `ptr` advancing; no requester granted twice before others served.
- Zero timer: `req`=0100, timer 0 -> `grant`=0100 cycle 1, `done`=0100 cycle 2, `tmr_start` stays 0.
- Watchdog: TIMEOUT=20, counter model never flags -> `err` for granted id exactly 21 cycles after `tmr_start`, `busy` drops same cycle; flag and limit coincident -> `done` only.
- Counter busy at grant: `tmr_busy` held high 5 cycles -> no `tmr_start` until cycle after `tmr_busy` falls; stray `tmr_flag` in ISSUE ignored.
- Reset mid-RUN: assert `rst` 2 cycles into service -> all outputs 0 next cycle, no done/err, `ptr`=0, next request of requester 0 granted first.

Source files
------------

// File: rtl/count_sched.sv
// Round-robin scheduler sharing one count_fsm wait-timer between N requesters.
// Grants one requester at a time, starts the counter and reports done or watchdog error.
module count_sched #(
  parameter int N       = 4,
  parameter int TW      = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N*TW-1:0]      req_timer,
  output logic [N-1:0]         grant,
  output logic [N-1:0]         done,
  output logic [N-1:0]         err,
  output logic                 busy,
  output logic [$clog2(N)-1:0] cur_id,
  output logic                 tmr_start,
  output logic [TW-1:0]        tmr_wait_timer,
  input  logic                 tmr_flag,
  input  logic                 tmr_busy
);
  localparam int IDW = $clog2(N);
  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_LIMIT = WDW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, RUN} state_t;

  state_t         state;
  logic [IDW-1:0] ptr;
  logic [WDW-1:0] wdog;
  logic [IDW:0]   pick;
  logic           sel_vld;
  logic [IDW-1:0] sel_id;
  logic [IDW-1:0] next_ptr;

  // First set request at or above p, wrapping; MSB of the result flags a hit.
  function automatic logic [IDW:0] rr_pick(input logic [N-1:0] r, input logic [IDW-1:0] p);
    logic [IDW:0] idx;
    logic [IDW:0] res;
    res = '0;
    for (int k = 0; k < N; k++) begin
      idx = {1'b0, p} + (IDW+1)'(k);
      if (idx >= (IDW+1)'(N)) idx = idx - (IDW+1)'(N);
      if (!res[IDW] && r[idx[IDW-1:0]]) res = {1'b1, idx[IDW-1:0]};
    end
    return res;
  endfunction

  function automatic logic [WDW-1:0] wd_inc(input logic [WDW-1:0] w);
    return (w == WD_LIMIT) ? w : w + 1'b1;
  endfunction

  always_comb begin
    pick     = rr_pick(req, ptr);
    sel_vld  = pick[IDW];
    sel_id   = pick[IDW-1:0];
    next_ptr = (cur_id == IDW'(N - 1)) ? '0 : cur_id + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      grant          <= '0;
      done           <= '0;
      err            <= '0;
      busy           <= 1'b0;
      cur_id         <= '0;
      tmr_start      <= 1'b0;
      tmr_wait_timer <= '0;
      ptr            <= '0;
      wdog           <= '0;
    end else begin
      done      <= '0;
      err       <= '0;
      tmr_start <= 1'b0;
      case (state)
        IDLE: begin
          if (sel_vld) begin
            grant          <= N'(1) << sel_id;
            cur_id         <= sel_id;
            tmr_wait_timer <= req_timer[sel_id*TW +: TW];
            busy           <= 1'b1;
            wdog           <= '0;
            state          <= ISSUE;
          end
        end
        ISSUE: begin
          // A zero wait never touches the counter.
          if (tmr_wait_timer == '0) begin
            done  <= grant;
            grant <= '0;
            busy  <= 1'b0;
            ptr   <= next_ptr;
            state <= IDLE;
          end else if (!tmr_busy) begin
            tmr_start <= 1'b1;
            wdog      <= '0;
            state     <= RUN;
          end else begin
            wdog <= wd_inc(wdog);
          end
        end
        RUN: begin
          // Expiry takes priority over the watchdog limit in the same cycle.
          if (tmr_flag) begin
            done  <= grant;
            grant <= '0;
            busy  <= 1'b0;
            ptr   <= next_ptr;
            state <= IDLE;
          end else if (wdog == WD_LIMIT) begin
            err   <= grant;
            grant <= '0;
            busy  <= 1'b0;
            ptr   <= next_ptr;
            state <= IDLE;
          end else begin
            wdog <= wd_inc(wdog);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
